// File: rtl/vga_timing_pkg.sv
// Default 1280x1024@60 raster timing constants for the 108 MHz pixel clock.
package vga_timing_pkg;

  localparam int CTR_W = 11;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 248;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 38;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL_DEFAULT = 1'b1;

endpackage

// File: rtl/sync_axis_counter.sv
// Wrapping raster axis counter; window flags describe the value the counter will hold after this edge.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W           = CTR_W,
  parameter int TOTAL       = H_TOTAL,
  parameter int ACT_LEN     = H_ACTIVE,
  parameter int PULSE_START = H_ACTIVE + H_FP,
  parameter int PULSE_END   = H_ACTIVE + H_FP + H_SYNC
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_carry_in,
  output logic [W-1:0] o_count,
  output logic         o_carry_out,
  output logic         o_next_active,
  output logic         o_next_pulse
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_last;

  assign w_last      = (r_count == W'(TOTAL - 1));
  assign o_carry_out = i_carry_in && w_last;

  always_comb begin
    w_next = r_count;
    if (o_carry_out)     w_next = '0;
    else if (i_carry_in) w_next = r_count + W'(1);
  end

  assign o_next_active = (w_next < W'(ACT_LEN));
  assign o_next_pulse  = (w_next >= W'(PULSE_START)) && (w_next < W'(PULSE_END));

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         r_count <= W'(TOTAL - 1);
    else if (i_carry_in) r_count <= w_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, data-enable and start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   HACTIVE  = H_ACTIVE,
  parameter int   HFP      = H_FP,
  parameter int   HSYNC    = H_SYNC,
  parameter int   HBP      = H_BP,
  parameter int   VACTIVE  = V_ACTIVE,
  parameter int   VFP      = V_FP,
  parameter int   VSYNC    = V_SYNC,
  parameter int   VBP      = V_BP,
  parameter logic SYNC_POL = SYNC_POL_DEFAULT
) (
  input  logic             CLK_108MHz,
  input  logic             reset,
  input  logic             enable,
  output logic [CTR_W-1:0] hctr_out,
  output logic [CTR_W-1:0] vctr_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       max_columns,
  output logic [7:0]       max_rows
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  logic w_h_carry, w_h_act, w_h_pulse;
  logic w_v_carry, w_v_act, w_v_pulse;
  logic r_de, r_hsync, r_vsync, r_line_start, r_frame_start;

  sync_axis_counter #(
    .W(CTR_W), .TOTAL(HTOTAL), .ACT_LEN(HACTIVE),
    .PULSE_START(HACTIVE + HFP), .PULSE_END(HACTIVE + HFP + HSYNC)
  ) u_h (
    .i_clk(CLK_108MHz), .i_reset(reset), .i_carry_in(enable),
    .o_count(hctr_out), .o_carry_out(w_h_carry),
    .o_next_active(w_h_act), .o_next_pulse(w_h_pulse)
  );

  sync_axis_counter #(
    .W(CTR_W), .TOTAL(VTOTAL), .ACT_LEN(VACTIVE),
    .PULSE_START(VACTIVE + VFP), .PULSE_END(VACTIVE + VFP + VSYNC)
  ) u_v (
    .i_clk(CLK_108MHz), .i_reset(reset), .i_carry_in(w_h_carry),
    .o_count(vctr_out), .o_carry_out(w_v_carry),
    .o_next_active(w_v_act), .o_next_pulse(w_v_pulse)
  );

  // Next position is (0,*) exactly when h wraps, and (0,0) exactly when v wraps too.
  always_ff @(posedge CLK_108MHz or posedge reset) begin
    if (reset) begin
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_de          <= w_h_act && w_v_act;
      r_hsync       <= w_h_pulse ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_v_pulse ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= w_h_carry;
      r_frame_start <= w_v_carry;
    end
  end

  assign de_out      = r_de;
  assign hsync_out   = r_hsync;
  assign vsync_out   = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign max_columns = 8'(HACTIVE / 8);
  assign max_rows    = 8'(VACTIVE / 8);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line-level timing, shrunk-raster instance for frame-level timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full 1280x1024 instance
  logic        rst_a, en_a;
  logic [10:0] h_a, v_a;
  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [7:0]  mc_a, mr_a;

  // Small raster: HTOTAL=24 (hsync 18..20), VTOTAL=14 (vsync lines 9..11)
  logic        rst_b, en_b;
  logic [10:0] h_b, v_b;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [7:0]  mc_b, mr_b;

  vga_timing_gen dut_a (
    .CLK_108MHz(clk), .reset(rst_a), .enable(en_a),
    .hctr_out(h_a), .vctr_out(v_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .de_out(de_a), .line_start(ls_a), .frame_start(fs_a),
    .max_columns(mc_a), .max_rows(mr_a)
  );

  vga_timing_gen #(
    .HACTIVE(16), .HFP(2), .HSYNC(3), .HBP(3),
    .VACTIVE(8), .VFP(1), .VSYNC(3), .VBP(2), .SYNC_POL(1'b1)
  ) dut_b (
    .CLK_108MHz(clk), .reset(rst_b), .enable(en_b),
    .hctr_out(h_b), .vctr_out(v_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .de_out(de_b), .line_start(ls_b), .frame_start(fs_b),
    .max_columns(mc_b), .max_rows(mr_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_a = 1'b1;
    step(3);
    total++; if (h_a !== 11'd1687) begin bad++; $display("FAIL reset_h: got %0d want 1687", h_a); end
    total++; if (v_a !== 11'd1065) begin bad++; $display("FAIL reset_v: got %0d want 1065", v_a); end
    total++; if ({de_a, hs_a, vs_a, ls_a, fs_a} !== 5'b00000) begin bad++; $display("FAIL reset_flags: got %b want 00000", {de_a, hs_a, vs_a, ls_a, fs_a}); end
    total++; if (mc_a !== 8'd160) begin bad++; $display("FAIL reset_maxcol: got %0d want 160", mc_a); end
    total++; if (mr_a !== 8'd128) begin bad++; $display("FAIL reset_maxrow: got %0d want 128", mr_a); end
    rst_a = 1'b0;
    step(1);
    total++; if (h_a !== 11'd0 || v_a !== 11'd0) begin bad++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", h_a, v_a); end
    total++; if ({de_a, ls_a, fs_a, hs_a, vs_a} !== 5'b11100) begin bad++; $display("FAIL first_flags: got %b want 11100", {de_a, ls_a, fs_a, hs_a, vs_a}); end
    total++; if (mc_a !== 8'd160 || mr_a !== 8'd128) begin bad++; $display("FAIL run_maxdim: got %0d/%0d want 160/128", mc_a, mr_a); end
  endtask

  task automatic test_line;
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    step(1279);
    total++; if (h_a !== 11'd1279 || de_a !== 1'b1) begin bad++; $display("FAIL de_last_vis: got h=%0d de=%b want h=1279 de=1", h_a, de_a); end
    step(1);
    total++; if (h_a !== 11'd1280 || de_a !== 1'b0) begin bad++; $display("FAIL de_fall: got h=%0d de=%b want h=1280 de=0", h_a, de_a); end
    for (int i = 0; i < 407; i++) begin
      step(1);
      if (hs_a === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(h_a);
        hs_last = int'(h_a);
      end
    end
    total++; if (h_a !== 11'd1687) begin bad++; $display("FAIL line_end: got %0d want 1687", h_a); end
    total++; if (hs_cnt != 112) begin bad++; $display("FAIL hsync_len: got %0d want 112", hs_cnt); end
    total++; if (hs_first != 1328 || hs_last != 1439) begin bad++; $display("FAIL hsync_window: got %0d..%0d want 1328..1439", hs_first, hs_last); end
    step(1);
    total++; if (h_a !== 11'd0 || v_a !== 11'd1) begin bad++; $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", h_a, v_a); end
    total++; if ({ls_a, fs_a, de_a, hs_a} !== 4'b1010) begin bad++; $display("FAIL line_wrap_flags: got %b want 1010", {ls_a, fs_a, de_a, hs_a}); end
  endtask

  task automatic test_freeze;
    step(500);
    en_a = 1'b0;
    step(10);
    total++; if (h_a !== 11'd500 || v_a !== 11'd1) begin bad++; $display("FAIL freeze_pos: got (%0d,%0d) want (500,1)", h_a, v_a); end
    total++; if ({de_a, ls_a, hs_a} !== 3'b100) begin bad++; $display("FAIL freeze_flags: got %b want 100", {de_a, ls_a, hs_a}); end
    en_a = 1'b1;
    step(1);
    total++; if (h_a !== 11'd501 || v_a !== 11'd1) begin bad++; $display("FAIL resume_pos: got (%0d,%0d) want (501,1)", h_a, v_a); end
    step(1187);
    en_a = 1'b0;
    step(5);
    total++; if (h_a !== 11'd0 || v_a !== 11'd2 || ls_a !== 1'b1) begin bad++; $display("FAIL freeze_strobe: got (%0d,%0d) ls=%b want (0,2) ls=1", h_a, v_a, ls_a); end
    en_a = 1'b1;
    step(1);
    total++; if (h_a !== 11'd1 || ls_a !== 1'b0) begin bad++; $display("FAIL strobe_drop: got h=%0d ls=%b want h=1 ls=0", h_a, ls_a); end
  endtask

  task automatic test_frame;
    int fs_cnt = 0, fs_at = -1, ls_cnt = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, vs_bad = 0;
    rst_b = 1'b1; en_b = 1'b1;
    step(2);
    total++; if (h_b !== 11'd23 || v_b !== 11'd13 || mc_b !== 8'd2 || mr_b !== 8'd1) begin bad++; $display("FAIL small_reset: got (%0d,%0d) %0d/%0d want (23,13) 2/1", h_b, v_b, mc_b, mr_b); end
    rst_b = 1'b0;
    step(1);
    total++; if (h_b !== 11'd0 || v_b !== 11'd0 || fs_b !== 1'b1) begin bad++; $display("FAIL small_first: got (%0d,%0d) fs=%b want (0,0) fs=1", h_b, v_b, fs_b); end
    for (int i = 1; i <= 336; i++) begin
      step(1);
      if (fs_b === 1'b1) begin fs_cnt++; if (fs_at < 0) fs_at = i; end
      if (ls_b === 1'b1) ls_cnt++;
      if (de_b === 1'b1) de_cnt++;
      if (hs_b === 1'b1) hs_cnt++;
      if (vs_b === 1'b1) begin
        vs_cnt++;
        if (v_b < 11'd9 || v_b > 11'd11) vs_bad++;
      end
      if (i == 335 && (h_b !== 11'd23 || v_b !== 11'd13)) begin
        total++; bad++; $display("FAIL pre_wrap: got (%0d,%0d) want (23,13)", h_b, v_b);
      end
    end
    total++; if (h_b !== 11'd0 || v_b !== 11'd0) begin bad++; $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", h_b, v_b); end
    total++; if (fs_cnt != 1 || fs_at != 336) begin bad++; $display("FAIL frame_period: got cnt=%0d at=%0d want cnt=1 at=336", fs_cnt, fs_at); end
    total++; if (ls_cnt != 14) begin bad++; $display("FAIL line_count: got %0d want 14", ls_cnt); end
    total++; if (de_cnt != 128) begin bad++; $display("FAIL de_count: got %0d want 128", de_cnt); end
    total++; if (hs_cnt != 42) begin bad++; $display("FAIL hsync_count: got %0d want 42", hs_cnt); end
    total++; if (vs_cnt != 72 || vs_bad != 0) begin bad++; $display("FAIL vsync_count: got %0d (outside %0d) want 72 (outside 0)", vs_cnt, vs_bad); end
  endtask

  task automatic test_reset_mid;
    step(259);
    total++; if (h_b !== 11'd19 || v_b !== 11'd10 || hs_b !== 1'b1 || vs_b !== 1'b1) begin bad++; $display("FAIL mid_pos: got (%0d,%0d) hs=%b vs=%b want (19,10) hs=1 vs=1", h_b, v_b, hs_b, vs_b); end
    #2 rst_b = 1'b1;
    #1;
    total++; if (h_b !== 11'd23 || v_b !== 11'd13) begin bad++; $display("FAIL async_reset_pos: got (%0d,%0d) want (23,13)", h_b, v_b); end
    total++; if ({de_b, hs_b, vs_b, ls_b, fs_b} !== 5'b00000) begin bad++; $display("FAIL async_reset_flags: got %b want 00000", {de_b, hs_b, vs_b, ls_b, fs_b}); end
    step(3);
    rst_b = 1'b0;
    step(1);
    total++; if (h_b !== 11'd0 || v_b !== 11'd0 || fs_b !== 1'b1 || de_b !== 1'b1) begin bad++; $display("FAIL restart: got (%0d,%0d) fs=%b de=%b want (0,0) fs=1 de=1", h_b, v_b, fs_b, de_b); end
    step(1);
    total++; if (h_b !== 11'd1 || fs_b !== 1'b0) begin bad++; $display("FAIL restart_step: got h=%0d fs=%b want h=1 fs=0", h_b, fs_b); end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    test_reset;
    test_line;
    test_freeze;
    test_frame;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
